// File: rtl/operand_unpacker.sv
// operand_unpacker
//   Read-side counterpart of the result packer. Walks an inclusive SRAM address range,
//   fetches MEM_WORD_SIZE-bit words and streams each one out as two DATA_W-bit operands,
//   lower half first, over a valid/ready handshake.
//
// Build option:
//   UNPACK_PREFETCH_EN - adds a second word buffer. The next word is fetched while the
//                        current one is being streamed, so valid_o stays high across word
//                        boundaries when ready_i is held high. Without it, every word costs
//                        a two-cycle read bubble.
//
// Ports:
//   clk_i        - clock, rising edge
//   rst_ni       - asynchronous active-low reset
//   start_i      - begin a transfer (sampled only while idle)
//   start_addr_i - first word address, latched on start
//   end_addr_i   - last word address (inclusive), latched on start
//   busy_o       - high while a transfer is in progress
//   done_o       - one-cycle completion pulse
//   mem_re_o     - SRAM read enable
//   mem_raddr_o  - SRAM read address (holds last value when not reading)
//   mem_rdata_i  - SRAM read data, valid one cycle after mem_re_o
//   data_o       - operand
//   valid_o      - data_o valid
//   ready_i      - consumer ready; a transfer happens on valid_o & ready_i
module operand_unpacker #(
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned MEM_WORD_SIZE = 64,
  parameter int unsigned ADDR_W        = 9
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [ADDR_W-1:0]        start_addr_i,
  input  logic [ADDR_W-1:0]        end_addr_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     mem_re_o,
  output logic [ADDR_W-1:0]        mem_raddr_o,
  input  logic [MEM_WORD_SIZE-1:0] mem_rdata_i,
  output logic [DATA_W-1:0]        data_o,
  output logic                     valid_o,
  input  logic                     ready_i
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_LOWER = 3'd3;
  localparam logic [2:0] S_UPPER = 3'd4;
  localparam logic [2:0] S_END   = 3'd5;

  logic [2:0]               state_q, state_d;
  logic [ADDR_W-1:0]        cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0]        end_addr_q, end_addr_d;
  logic [ADDR_W-1:0]        raddr_q, raddr_d;
  logic [MEM_WORD_SIZE-1:0] word_q, word_d;
  logic                     last_word;

`ifdef UNPACK_PREFETCH_EN
  logic [MEM_WORD_SIZE-1:0] pf_word_q, pf_word_d;
  logic                     pf_pend_q, pf_pend_d;     // prefetch read in flight
  logic                     pf_valid_q, pf_valid_d;   // pf_word_q holds the next word
  logic                     pf_issued_q, pf_issued_d; // prefetch already issued for this word
`endif

  // Equality test (not a compare against cur+1) so the top address never wraps to 0.
  assign last_word = (cur_addr_q == end_addr_q);

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    end_addr_d  = end_addr_q;
    raddr_d     = raddr_q;
    word_d      = word_q;
    mem_re_o    = 1'b0;
    mem_raddr_o = raddr_q;
    valid_o     = 1'b0;
    data_o      = '0;
    busy_o      = (state_q != S_IDLE);
    done_o      = (state_q == S_END);
`ifdef UNPACK_PREFETCH_EN
    pf_word_d   = pf_word_q;
    pf_pend_d   = pf_pend_q;
    pf_valid_d  = pf_valid_q;
    pf_issued_d = pf_issued_q;
    // Prefetch data lands one cycle after its read, whatever state we are in.
    if (pf_pend_q) begin
      pf_word_d  = mem_rdata_i;
      pf_valid_d = 1'b1;
      pf_pend_d  = 1'b0;
    end
`endif

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          cur_addr_d = start_addr_i;
          end_addr_d = end_addr_i;
          state_d    = (end_addr_i < start_addr_i) ? S_END : S_READ;
        end
      end

      S_READ: begin
        mem_re_o    = 1'b1;
        mem_raddr_o = cur_addr_q;
        raddr_d     = cur_addr_q;
        state_d     = S_WAIT;
      end

      S_WAIT: begin
        word_d  = mem_rdata_i;
        state_d = S_LOWER;
      end

      S_LOWER: begin
        valid_o = 1'b1;
        data_o  = word_q[DATA_W-1:0];
`ifdef UNPACK_PREFETCH_EN
        if (!pf_issued_q && !last_word) begin
          mem_re_o    = 1'b1;
          mem_raddr_o = cur_addr_q + ADDR_W'(1);
          raddr_d     = cur_addr_q + ADDR_W'(1);
          pf_pend_d   = 1'b1;
          pf_issued_d = 1'b1;
        end
`endif
        if (ready_i) begin
          state_d = S_UPPER;
        end
      end

      S_UPPER: begin
        valid_o = 1'b1;
        data_o  = word_q[MEM_WORD_SIZE-1:DATA_W];
        if (ready_i) begin
          if (last_word) begin
            state_d = S_END;
          end else begin
            cur_addr_d = cur_addr_q + ADDR_W'(1);
`ifdef UNPACK_PREFETCH_EN
            pf_issued_d = 1'b0;
            if (pf_valid_q) begin
              word_d     = pf_word_q;
              pf_valid_d = 1'b0;
              state_d    = S_LOWER;
            end else if (pf_pend_q) begin
              // Prefetch data is on the bus this very cycle: bypass the buffer.
              word_d     = mem_rdata_i;
              pf_valid_d = 1'b0;
              pf_pend_d  = 1'b0;
              state_d    = S_LOWER;
            end else begin
              state_d = S_READ;
            end
`else
            state_d = S_READ;
`endif
          end
        end
      end

      S_END: begin
        state_d = S_IDLE;
`ifdef UNPACK_PREFETCH_EN
        pf_pend_d   = 1'b0;
        pf_valid_d  = 1'b0;
        pf_issued_d = 1'b0;
`endif
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      cur_addr_q <= '0;
      end_addr_q <= '0;
      raddr_q    <= '0;
      word_q     <= '0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      end_addr_q <= end_addr_d;
      raddr_q    <= raddr_d;
      word_q     <= word_d;
    end
  end

`ifdef UNPACK_PREFETCH_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pf_word_q   <= '0;
      pf_pend_q   <= 1'b0;
      pf_valid_q  <= 1'b0;
      pf_issued_q <= 1'b0;
    end else begin
      pf_word_q   <= pf_word_d;
      pf_pend_q   <= pf_pend_d;
      pf_valid_q  <= pf_valid_d;
      pf_issued_q <= pf_issued_d;
    end
  end
`endif

endmodule

// File: tb/tb_operand_unpacker.sv
// Testbench for operand_unpacker: SRAM model, scoreboard of expected operands checked by a
// negedge monitor, and directed cycle-level checks.
module tb_operand_unpacker;

  localparam int DW = 32;
  localparam int MW = 64;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          start_i = 1'b0;
  logic [AW-1:0] start_addr_i = '0;
  logic [AW-1:0] end_addr_i = '0;
  logic          busy_o, done_o, mem_re_o, valid_o;
  logic [AW-1:0] mem_raddr_o;
  logic [MW-1:0] mem_rdata = '0;
  logic [DW-1:0] data_o;
  logic          ready_i = 1'b0;

  operand_unpacker #(.DATA_W(DW), .MEM_WORD_SIZE(MW), .ADDR_W(AW)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .start_addr_i(start_addr_i),
    .end_addr_i  (end_addr_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .mem_re_o    (mem_re_o),
    .mem_raddr_o (mem_raddr_o),
    .mem_rdata_i (mem_rdata),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i)
  );

  always #5 clk = ~clk;

  // SRAM model with one-cycle read latency and a log of every read address.
  logic [MW-1:0] mem [0:511];
  int unsigned   rd_log[$];
  always @(posedge clk) begin
    if (mem_re_o) begin
      mem_rdata <= mem[mem_raddr_o];
      rd_log.push_back(int'(mem_raddr_o));
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int            n_cmp = 0;
  int            n_bad = 0;
  int            done_cnt = 0;
  int            last_xfer_edge = 0;
  int            s_cyc = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mon_exp;

  // Monitor: a transfer is committed at the next rising edge when valid_o & ready_i.
  always @(negedge clk) begin
    if (done_o) done_cnt = done_cnt + 1;
    if (rst_ni && valid_o && ready_i) begin
      n_cmp = n_cmp + 1;
      if (exp_q.size() == 0) begin
        n_bad = n_bad + 1;
        $display("FAIL sb_unexpected: got data_o=%h, required no transfer", data_o);
      end else begin
        mon_exp = exp_q.pop_front();
        if (data_o !== mon_exp) begin
          n_bad = n_bad + 1;
          $display("FAIL sb_data: got data_o=%h, required %h", data_o, mon_exp);
        end
      end
      last_xfer_edge = cyc + 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp = n_cmp + 1;
    if (act !== req) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive start for one edge (edge 0); returns in the first cycle after it.
  task automatic start(input int sa, input int ea);
    start_addr_i = AW'(sa);
    end_addr_i   = AW'(ea);
    start_i      = 1'b1;
    tick();
    start_i = 1'b0;
    s_cyc   = cyc;
  endtask

  task automatic wait_done(input string name, input int limit);
    int k;
    k = 0;
    while (!done_o && k < limit) begin
      tick();
      k++;
    end
    chk(name, done_o, 1'b1);
  endtask

  task automatic push_word(input logic [63:0] w);
    exp_q.push_back(w[31:0]);
    exp_q.push_back(w[63:32]);
  endtask

  function automatic int log_at(input int i);
    if (i < rd_log.size()) return int'(rd_log[i]);
    return -1;
  endfunction

  int d0;
  int k;
  int hit0;

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 64'hDEAD_BEEF_DEAD_BEEF;
    mem[0]   = 64'h1000_0001_2000_0002;
    mem[1]   = 64'h1100_0011_2100_0021;
    mem[2]   = 64'h1200_0012_2200_0022;
    mem[3]   = 64'h1300_0013_2300_0023;
    mem[4]   = 64'hAAAA_BBBB_1111_2222;
    mem[6]   = 64'h6666_0006_7777_0006;
    mem[7]   = 64'h6666_0007_7777_0007;
    mem[510] = 64'hFE10_0000_0000_EF10;
    mem[511] = 64'hFF11_1111_1111_11FF;

    // Reset state
    tick();
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_valid", valid_o, 1'b0);
    chk("rst_re", mem_re_o, 1'b0);
    chk("rst_data", data_o, 32'h0);
    rst_ni = 1'b1;
    tick();
    chk("idle_done", done_o, 1'b0);
    chk("idle_raddr", mem_raddr_o, 9'h0);

    // 1: single word at 4, latency and operand order
    ready_i = 1'b1;
    rd_log.delete();
    exp_q.push_back(32'h1111_2222);
    exp_q.push_back(32'hAAAA_BBBB);
    start(4, 4);
    chk("t1_c1_re", mem_re_o, 1'b1);
    chk("t1_c1_raddr", mem_raddr_o, 9'd4);
    chk("t1_c1_busy", busy_o, 1'b1);
    chk("t1_c1_valid", valid_o, 1'b0);
    tick();
    chk("t1_c2_re", mem_re_o, 1'b0);
    chk("t1_c2_valid", valid_o, 1'b0);
    tick();
    chk("t1_c3_valid", valid_o, 1'b1);
    chk("t1_c3_data", data_o, 32'h1111_2222);
    tick();
    chk("t1_c4_data", data_o, 32'hAAAA_BBBB);
    chk("t1_c4_done", done_o, 1'b0);
    tick();
    chk("t1_c5_done", done_o, 1'b1);
    chk("t1_c5_valid", valid_o, 1'b0);
    tick();
    chk("t1_c6_done", done_o, 1'b0);
    chk("t1_c6_busy", busy_o, 1'b0);
    chk("t1_nreads", rd_log.size(), 1);

    // 2: range 0..3 with ready held high
    rd_log.delete();
    for (int i = 0; i < 4; i++) push_word(mem[i]);
    start(0, 3);
    wait_done("t2_done", 100);
`ifdef UNPACK_PREFETCH_EN
    chk("t2_last_xfer_edge", last_xfer_edge - s_cyc, 10);
`else
    chk("t2_last_xfer_edge", last_xfer_edge - s_cyc, 16);
`endif
    chk("t2_nreads", rd_log.size(), 4);
    for (int i = 0; i < 4; i++) chk("t2_read_addr", log_at(i), i);
    tick();

    // 3: back-pressure during UPPER
    ready_i = 1'b0;
    rd_log.delete();
    push_word(mem[6]);
    push_word(mem[7]);
    start(6, 7);
    k = 0;
    while (!valid_o && k < 20) begin
      tick();
      k++;
    end
    chk("t3_lower_valid", valid_o, 1'b1);
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t3_stall_valid", valid_o, 1'b1);
      chk("t3_stall_data", data_o, 32'h6666_0006);
      chk("t3_stall_re", mem_re_o, 1'b0);
      tick();
    end
    ready_i = 1'b1;
    wait_done("t3_done", 50);
    chk("t3_nreads", rd_log.size(), 2);
    chk("t3_read1", log_at(1), 7);
    tick();

    // 4: end < start -> no reads, done still pulses
    rd_log.delete();
    d0 = done_cnt;
    start(10, 5);
    chk("t4_re", mem_re_o, 1'b0);
    chk("t4_done", done_o, 1'b1);
    tick();
    chk("t4_busy", busy_o, 1'b0);
    chk("t4_done_clr", done_o, 1'b0);
    chk("t4_nreads", rd_log.size(), 0);
    chk("t4_done_cnt", done_cnt - d0, 1);

    // 5: top of address space, no wrap
    rd_log.delete();
    d0 = done_cnt;
    push_word(mem[510]);
    push_word(mem[511]);
    start(510, 511);
    wait_done("t5_done", 50);
    tick();
    tick();
    chk("t5_nreads", rd_log.size(), 2);
    chk("t5_read0", log_at(0), 510);
    chk("t5_read1", log_at(1), 511);
    hit0 = 0;
    foreach (rd_log[i]) if (rd_log[i] == 0) hit0++;
    chk("t5_no_addr0", hit0, 0);
    chk("t5_done_cnt", done_cnt - d0, 1);
    chk("t5_busy", busy_o, 1'b0);

    // 6: reset mid-range, then a fresh single-word run
    for (int i = 0; i < 4; i++) push_word(mem[i]);
    start(0, 3);
    repeat (6) tick();
    rst_ni = 1'b0;
    #1;
    chk("t6_rst_busy", busy_o, 1'b0);
    chk("t6_rst_done", done_o, 1'b0);
    chk("t6_rst_re", mem_re_o, 1'b0);
    chk("t6_rst_raddr", mem_raddr_o, 9'h0);
    chk("t6_rst_data", data_o, 32'h0);
    chk("t6_rst_valid", valid_o, 1'b0);
    exp_q.delete();
    d0 = done_cnt;
    repeat (3) tick();
    rst_ni = 1'b1;
    repeat (3) tick();
    chk("t6_no_done", done_cnt - d0, 0);
    chk("t6_idle_busy", busy_o, 1'b0);
    rd_log.delete();
    push_word(mem[2]);
    start(2, 2);
    wait_done("t6_done", 50);
    tick();
    chk("t6_nreads", rd_log.size(), 1);
    chk("t6_read0", log_at(0), 2);
    chk("t6_done_cnt", done_cnt - d0, 1);

    chk("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Safety net against a hung run.
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
